// File: rtl/seq_div4_if.sv
// ---------------------------------------------------------------------------
// seq_div4_if -- operand/result bundle for the 4-bit sequential divider.
//
//   start       : request a division (requester -> divider)
//   dividend    : 4-bit unsigned dividend (requester -> divider)
//   divisor     : 4-bit unsigned divisor (requester -> divider)
//   quotient    : 4-bit registered quotient (divider -> requester)
//   remainder   : 4-bit registered remainder (divider -> requester)
//   busy        : division in progress (divider -> requester)
//   done        : one-cycle completion pulse (divider -> requester)
//   div_by_zero : last accepted division had divisor 0 (divider -> requester)
//
// master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface seq_div4_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_div4.sv
// ---------------------------------------------------------------------------
// seq_div4 -- 4-bit unsigned restoring divider, one quotient bit per cycle.
//
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : seq_div4_if.slave -- start/dividend/divisor in;
//          quotient/remainder/busy/done/div_by_zero out
//
// Sequence: IDLE -(start, divisor!=0)-> CALC x4 -> DONE -> IDLE.
//           IDLE -(start, divisor==0)-> DONE -> IDLE.
// Results only change on entry to DONE and hold until the next DONE or reset.
// ---------------------------------------------------------------------------
module seq_div4 (
    input  logic          clk,
    input  logic          rst,
    seq_div4_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [3:0] r_rem;        // partial remainder R
    logic [3:0] r_q;          // dividend/quotient shift register Q
    logic [1:0] r_cnt;        // CALC step counter 0..3
    logic [3:0] r_divisor;    // divisor latched on the accepting edge
    logic [3:0] r_quotient;
    logic [3:0] r_remainder;
    logic       r_dbz;

    // One restoring step: bring the next dividend bit into R, trial-subtract.
    logic [4:0] w_p;
    logic       w_ge;
    logic [3:0] w_rem_next;
    logic [3:0] w_q_next;

    assign w_p        = {r_rem, r_q[3]};
    assign w_ge       = (w_p >= {1'b0, r_divisor});
    // When w_ge holds the difference is below 16, so 4-bit arithmetic is exact.
    assign w_rem_next = w_ge ? (w_p[3:0] - r_divisor) : w_p[3:0];
    assign w_q_next   = {r_q[2:0], w_ge};

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves the output
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_next_state = (bus.divisor == 4'd0) ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == 2'd3) w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic (decoded from the registered state, so glitch-free per cycle)
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (r_state)
            S_CALC:  bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= 4'd0;
            r_q         <= 4'd0;
            r_cnt       <= 2'd0;
            r_divisor   <= 4'd0;
            r_quotient  <= 4'd0;
            r_remainder <= 4'd0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == 4'd0) begin
                            r_quotient  <= 4'hF;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_divisor <= bus.divisor;
                            r_rem     <= 4'd0;
                            r_q       <= bus.dividend;
                            r_cnt     <= 2'd0;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 2'd1;
                    // Publish only after the last step so the outputs never
                    // show intermediate values.
                    if (r_cnt == 2'd3) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                        r_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: doc/seq_div4.md
SEQ_DIV4 -- requirements
Module: seq_div4

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have the port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-004 The module SHALL have the ports dividend and divisor, input, 4 bits each: unsigned operands, sampled on the accepting edge.
REQ-005 The module SHALL have the port quotient, output, 4 bits: unsigned quotient, registered.
REQ-006 The module SHALL have the port remainder, output, 4 bits: unsigned remainder, registered.
REQ-007 The module SHALL have the port busy, output, 1 bit: high while a division is in progress (CALC state).
REQ-008 The module SHALL have the port done, output, 1 bit: one-cycle pulse, high in the DONE state.
REQ-009 The module SHALL have the port div_by_zero, output, 1 bit: high when the last accepted division had divisor == 0; held with the results.

Function
REQ-010 The module SHALL implement exactly three states: IDLE, CALC and DONE.
REQ-011 In IDLE with start=1 and divisor!=0, the module SHALL latch both operands, clear its 4-bit partial remainder R, load a shift register Q with dividend, load a step counter with 0, and enter CALC.
REQ-012 In IDLE with start=1 and divisor==0, the module SHALL enter DONE directly with quotient=4'hF, remainder=dividend and div_by_zero=1.
REQ-013 In CALC, each cycle SHALL perform one restoring step, exactly as follows:
  - form the 5-bit value P={1'b0,R[3:0]} shifted left by 1, OR Q[3];
  - shift Q left by 1;
  - if P >= {1'b0,divisor}: R = (P - divisor)[3:0] and Q[0] = 1;
  - otherwise: R = P[3:0] and Q[0] = 0.
REQ-014 The CALC state SHALL last exactly 4 cycles, with the counter advancing 0..3; after the step with count 3, the state SHALL become DONE.
REQ-015 On entering DONE from CALC, quotient=Q, remainder=R and div_by_zero=0 SHALL be registered.
REQ-016 Latency SHALL be: accepting edge at cycle 0, done=1 during cycle 5 for nonzero divisor, or during cycle 1 for a zero divisor.
REQ-017 DONE SHALL last one cycle and then return unconditionally to IDLE.
REQ-018 start SHALL be ignored in CALC and DONE, and the operands SHALL NOT be resampled there.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next DONE or reset.
REQ-020 In CALC, quotient and remainder SHALL keep the previous result; intermediate values SHALL NOT appear on them.
REQ-021 The results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-022 busy SHALL be 1 exactly in CALC.
REQ-023 done SHALL be 1 exactly in DONE.

Reset
REQ-024 When rst=1 on a clock edge, the module SHALL go to IDLE and clear quotient, remainder, busy, done, div_by_zero, R, Q and the counter to 0.
REQ-025 rst SHALL take priority over start and over any in-progress CALC or DONE.
REQ-026 After a reset mid-operation, no done pulse from the aborted division SHALL ever appear.
REQ-027 start asserted in the same cycle that rst is released SHALL NOT be accepted; start SHALL be accepted on the first edge with rst=0 and the state in IDLE.

Verification
REQ-028 Scenario: dividend=13, divisor=4, start pulse -> busy=1 for cycles 1-4, done=1 in cycle 5, quotient=3, remainder=1, div_by_zero=0.
REQ-029 Scenario: 15/1 -> quotient=15, remainder=0; then 3/7 -> quotient=0, remainder=3; results held after done.
REQ-030 Scenario: dividend=9, divisor=0 -> done=1 in cycle 1, quotient=4'hF, remainder=9, div_by_zero=1, busy never 1.
REQ-031 Scenario: start with 14/3; in cycle 2, start with 1/1 -> second request ignored, done in cycle 5 with quotient=4, remainder=2.
REQ-032 Scenario: start with 10/3, rst=1 in cycle 3 -> next cycle all outputs 0 and state IDLE, no done pulse; then 10/3 -> quotient=3, remainder=1.
REQ-033 Scenario: exhaustive sweep of all 256 operand pairs back-to-back -> every result matches REQ-021, or the divide-by-zero values for divisor 0.
